uram_write: RTL and testbench

Fill-side controller for the exponent-scan URAM. On an `en_fill` pulse it drains `n_words` WIDTH-bit entries from an upstream standard-read FIFO and writes them into consecutive URAM addresses starting at `base_addr`. It is the producer for the bit-scan read engine that later fetches entries selected by the exponent bits. While that engine is scanning (`rd_busy`), no new FIFO reads are issued, so the write and read paths never collide on the URAM port.

---
 rtl/uram_pkg.sv | 18 +
 rtl/uram_write.sv | 124 ++++++++++++
 tb/tb_uram_write.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uram_pkg.sv
// uram_pkg: definitions shared by the exponent-scan URAM fill controller and
// the bit-scan read engine.
//   WIDTH_DEF     : default URAM entry width in bits
//   URAM_ADDR_DEF : default URAM address width (depth = 2**URAM_ADDR_DEF)
//   fill_state_t  : fill controller state encoding
package uram_pkg;

    localparam int WIDTH_DEF     = 3072;
    localparam int URAM_ADDR_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/uram_write.sv
// uram_write: fill-side controller for the exponent-scan URAM.
// On en_fill it drains n_words entries from a standard-read FIFO and writes
// them to consecutive URAM addresses starting at base_addr (wrapping modulo
// the URAM depth). New FIFO reads are held off while rd_busy or rempty.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   en_fill                start pulse (only honoured in IDLE)
//   base_addr, n_words     transfer descriptor, sampled with en_fill
//   rd_busy                read engine active, blocks new FIFO reads
//   rempty                 source FIFO empty
//   rd_fifo                registered FIFO read strobe
//   data_fifo              FIFO data, valid the cycle after rd_fifo
//   wr_uram, wr_addr,
//   data_uram              registered URAM write port
//   filling                controller busy (state != IDLE)
//   fill_done              one-cycle pulse after the last write
module uram_write
    import uram_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int URAM_ADDR = URAM_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_fill,
    input  logic [URAM_ADDR-1:0] base_addr,
    input  logic [URAM_ADDR:0]   n_words,
    input  logic                 rd_busy,
    input  logic                 rempty,
    output logic                 rd_fifo,
    input  logic [WIDTH-1:0]     data_fifo,
    output logic                 wr_uram,
    output logic [URAM_ADDR-1:0] wr_addr,
    output logic [WIDTH-1:0]     data_uram,
    output logic                 filling,
    output logic                 fill_done
);

    fill_state_t          state;
    logic [URAM_ADDR:0]   n_reg;
    logic [URAM_ADDR:0]   issued;
    logic [URAM_ADDR:0]   written;
    logic [URAM_ADDR-1:0] wptr;
    logic                 rd_delay;
    logic                 can_issue;

    assign can_issue = !rempty && !rd_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            issued    <= '0;
            written   <= '0;
            wptr      <= '0;
            rd_delay  <= 1'b0;
            rd_fifo   <= 1'b0;
            wr_uram   <= 1'b0;
            wr_addr   <= '0;
            data_uram <= '0;
            filling   <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            rd_fifo   <= 1'b0;
            fill_done <= 1'b0;

            // Two-stage write pipeline: strobe -> data returns -> URAM write.
            // Runs independently of the FSM so in-flight reads always land.
            rd_delay <= rd_fifo;
            wr_uram  <= rd_delay;
            if (rd_delay) begin
                data_uram <= data_fifo;
                wr_addr   <= wptr;
                wptr      <= wptr + 1'b1;   // wraps silently at the top
                written   <= written + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (en_fill) begin
                        n_reg   <= n_words;
                        wptr    <= base_addr;
                        written <= '0;
                        filling <= 1'b1;
                        if (n_words == '0) begin
                            issued    <= '0;
                            state     <= DONE;
                            fill_done <= 1'b1;
                        end else begin
                            // First strobe may go out on the same edge that
                            // accepts the start pulse.
                            state   <= FILL;
                            rd_fifo <= can_issue;
                            issued  <= can_issue ? {{URAM_ADDR{1'b0}}, 1'b1} : '0;
                        end
                    end
                end
                FILL: begin
                    if (issued == n_reg) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        rd_fifo <= 1'b1;
                        issued  <= issued + 1'b1;
                    end
                end
                DRAIN: begin
                    if (written == n_reg) begin
                        state     <= DONE;
                        fill_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    filling <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    filling <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uram_write.sv
// tb_uram_write: self-checking bench for uram_write. A queue-based FIFO
// feeds the DUT; the expected URAM image of each transfer is
// (base + i) mod depth <- i-th word pushed, checked in order along with
// strobe-to-write latency, stall legality and completion timing.
module tb_uram_write;
    import uram_pkg::*;

    localparam int W     = 64;
    localparam int A     = URAM_ADDR_DEF;
    localparam int DEPTH = 1 << A;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_fill = 1'b0;
    logic [A-1:0] base_addr = '0;
    logic [A:0]   n_words = '0;
    logic         rd_busy = 1'b0;
    logic         rempty = 1'b0;
    logic         rd_fifo;
    logic [W-1:0] data_fifo = '0;
    logic         wr_uram;
    logic [A-1:0] wr_addr;
    logic [W-1:0] data_uram;
    logic         filling;
    logic         fill_done;

    uram_write #(.WIDTH(W), .URAM_ADDR(A)) dut (
        .clk(clk), .rst_n(rst_n), .en_fill(en_fill), .base_addr(base_addr),
        .n_words(n_words), .rd_busy(rd_busy), .rempty(rempty), .rd_fifo(rd_fifo),
        .data_fifo(data_fifo), .wr_uram(wr_uram), .wr_addr(wr_addr),
        .data_uram(data_uram), .filling(filling), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rd_cnt = 0;
    int overread = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    bit pend = 1'b0;
    bit prev_block = 1'b0;

    logic [W-1:0] fifo_q[$];
    int           rd_cyc_q[$];
    logic [A-1:0] wa_q[$];
    logic [W-1:0] wd_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (pend) begin
            if (fifo_q.size() == 0) overread++;
            else data_fifo <= fifo_q.pop_front();
        end
    end

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        pend = rd_fifo && rst_n;
        if (rst_n) begin
            if (rd_fifo) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                chk("rd_while_blocked", prev_block, 0);
            end
            if (wr_uram) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(data_uram);
                last_wr_cyc = cyc;
                chk("write_has_read", rd_cyc_q.size() > 0, 1);
                if (rd_cyc_q.size() > 0) chk("rd_to_wr_latency", cyc - rd_cyc_q.pop_front(), 2);
            end
            if (fill_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_block = rempty || rd_busy;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rd_fifo"}, rd_fifo, 0);
        chk({tag, "_wr_uram"}, wr_uram, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_data_uram"}, data_uram, 0);
        chk({tag, "_filling"}, filling, 0);
        chk({tag, "_fill_done"}, fill_done, 0);
    endtask

    // mode 0: no stalls, 1: random stalls, 2: scripted empty/busy windows
    task automatic run_fill(input int base, input int n, input int mode, input bit restart,
                            output int nwr, output int first, output int last, output int lat);
        logic [W-1:0] exp_d[$];
        int c0, budget, rd0, e_left, b_left;
        bit e_done, b_done;
        logic [W-1:0] w;
        wa_q.delete(); wd_q.delete(); rd_cyc_q.delete();
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom()};
            exp_d.push_back(w);
            fifo_q.push_back(w);
        end
        @(posedge clk); #1;
        base_addr = base[A-1:0];
        n_words   = n[A:0];
        en_fill   = 1'b1;
        c0  = cyc;
        rd0 = rd_cnt;
        e_left = 0; b_left = 0; e_done = 0; b_done = 0;
        @(posedge clk); #1;
        en_fill = 1'b0;
        chk("filling_after_start", filling, 1);
        budget = 0;
        while (done_cnt == 0 && budget < 20000) begin
            case (mode)
                1: begin
                    rempty  = ($urandom_range(3) == 0);
                    rd_busy = ($urandom_range(4) == 0);
                end
                2: begin
                    if (!e_done && rd_cnt - rd0 >= 2) begin e_done = 1; e_left = 3; end
                    if (!b_done && rd_cnt - rd0 >= 5) begin b_done = 1; b_left = 2; end
                    rempty  = (e_left > 0);
                    rd_busy = (b_left > 0);
                    if (e_left > 0) e_left--;
                    if (b_left > 0) b_left--;
                end
                default: begin rempty = 0; rd_busy = 0; end
            endcase
            if (restart && budget == 2) begin
                base_addr = '0; n_words = 8; en_fill = 1'b1;
            end else begin
                en_fill = 1'b0;
            end
            @(posedge clk); #1;
            budget++;
        end
        rempty = 0; rd_busy = 0; en_fill = 0;
        chk("fill_done_seen", done_cnt, 1);
        if (n > 0) chk("done_after_last_write", done_cyc, last_wr_cyc + 1);
        chk("filling_low_after_done", filling, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("one_done_pulse", done_cnt, 1);
        chk("write_count", wa_q.size(), n);
        chk("read_count", rd_cnt - rd0, n);
        chk("fifo_drained", fifo_q.size(), 0);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk("wr_addr_seq", wa_q[i], (base + i) % DEPTH);
            chk("wr_data_seq", wd_q[i], exp_d[i]);
        end
        nwr   = wa_q.size();
        first = (nwr > 0) ? int'(wa_q[0]) : 0;
        last  = (nwr > 0) ? int'(wa_q[nwr-1]) : 0;
        lat   = done_cyc - c0;
    endtask

    typedef struct {
        int base; int n; int mode; bit restart;
        int exp_wr; int exp_first; int exp_last; int exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int nwr, first, last, lat, budget;
        vecs[0] = '{0,    4,    0, 0, 4,    0,    3,    7};
        vecs[1] = '{4094, 4,    0, 0, 4,    4094, 1,    7};
        vecs[2] = '{0,    0,    0, 0, 0,    0,    0,    1};
        vecs[3] = '{4095, 1,    0, 0, 1,    4095, 4095, 4};
        vecs[4] = '{100,  10,   2, 0, 10,   100,  109,  -1};
        vecs[5] = '{50,   4,    0, 1, 4,    50,   53,   7};
        vecs[6] = '{7,    4096, 0, 0, 4096, 7,    6,    4099};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            run_fill(vecs[v].base, vecs[v].n, vecs[v].mode, vecs[v].restart, nwr, first, last, lat);
            chk("tbl_writes", nwr, vecs[v].exp_wr);
            if (vecs[v].exp_wr > 0) begin
                chk("tbl_first_addr", first, vecs[v].exp_first);
                chk("tbl_last_addr", last, vecs[v].exp_last);
            end
            if (vecs[v].exp_lat >= 0) chk("tbl_done_latency", lat, vecs[v].exp_lat);
        end

        for (int r = 0; r < 8; r++) begin
            run_fill($urandom_range(DEPTH-1), $urandom_range(40, 1), 1, 0, nwr, first, last, lat);
        end

        // Reset asserted while the third write is on the URAM port.
        wa_q.delete(); wd_q.delete(); rd_cyc_q.delete();
        for (int i = 0; i < 6; i++) fifo_q.push_back({$urandom(), $urandom()});
        @(posedge clk); #1;
        base_addr = 10; n_words = 6; en_fill = 1'b1;
        @(posedge clk); #1;
        en_fill = 1'b0;
        budget = 0;
        while (!(wr_uram && wa_q.size() == 2) && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("reach_third_write", budget < 50, 1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        check_zero("held_reset");
        fifo_q.delete(); rd_cyc_q.delete();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_fill(200, 2, 0, 0, nwr, first, last, lat);
        chk("post_reset_writes", nwr, 2);
        chk("post_reset_first", first, 200);
        chk("post_reset_latency", lat, 5);

        chk("no_overread", overread, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
